// File: rtl/ro_meas_pkg.sv
// Shared types and constants for the ring-oscillator frequency meter.
//   ro_meas_state_e : measurement FSM states
//   SETTLE_CYCLES   : synchroniser flush time after a channel change
//   SETTLE_W        : width of the settle down-counter
package ro_meas_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    GATE   = 2'd2,
    DONE   = 2'd3
  } ro_meas_state_e;

  localparam int SETTLE_CYCLES = 3;
  localparam int SETTLE_W      = $clog2(SETTLE_CYCLES + 1);

endpackage

// File: rtl/ro_sync_edge.sv
// Two-flop synchroniser followed by a rising-edge detect register.
// Ports:
//   wb_clk_i  : reference clock
//   wb_rst_ni : asynchronous active-low reset
//   d_async   : raw oscillator signal, asynchronous to wb_clk_i
//   rise      : one-cycle high when the synchronised signal goes 0->1
module ro_sync_edge (
  input  logic wb_clk_i,
  input  logic wb_rst_ni,
  input  logic d_async,
  output logic rise
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  always_comb begin
    meta_d = d_async;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign rise = sync_q & ~prev_q;

endmodule

// File: rtl/ro_freq_meter.sv
// On-chip ring-oscillator frequency meter. Selects one of N_CH oscillator
// outputs, synchronises it, counts rising edges over a gate window of
// gate_cycles reference-clock cycles and holds the result for readout.
// Ports:
//   wb_clk_i    : reference clock, all state on its rising edge
//   wb_rst_ni   : asynchronous active-low reset
//   ro_in       : raw oscillator outputs (asynchronous)
//   sel         : channel select, latched at start
//   gate_cycles : gate length in clock cycles, latched at start
//   start       : one-cycle measurement request (IDLE only)
//   abort       : cancel a measurement in progress
//   busy        : high whenever the FSM is not IDLE
//   done        : one-cycle pulse when count/overflow update
//   count       : last completed edge count
//   overflow    : last measurement saturated the counter
//   ro_mon      : live combinational mux of ro_in[sel] for a pad
module ro_freq_meter
  import ro_meas_pkg::*;
#(
  parameter int N_CH   = 10,
  parameter int SEL_W  = (N_CH > 1) ? $clog2(N_CH) : 1,
  parameter int GATE_W = 16,
  parameter int CNT_W  = 24
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_ni,
  input  logic [N_CH-1:0]   ro_in,
  input  logic [SEL_W-1:0]  sel,
  input  logic [GATE_W-1:0] gate_cycles,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  count,
  output logic              overflow,
  output logic              ro_mon
);

  // Zero-padded to the full select range so out-of-range selects read 0.
  localparam int PAD_W = 1 << SEL_W;

  logic [PAD_W-1:0] ro_pad;
  logic             ro_sel;
  logic             rise;

  ro_meas_state_e    state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [GATE_W-1:0] gate_q, gate_d;
  logic [GATE_W-1:0] gate_rem_q, gate_rem_d;
  logic [SETTLE_W-1:0] settle_cnt_q, settle_cnt_d;
  logic [CNT_W-1:0]  edge_cnt_q, edge_cnt_d;
  logic              ovf_q, ovf_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              done_q, done_d;

  always_comb begin
    ro_pad            = '0;
    ro_pad[N_CH-1:0]  = ro_in;
  end

  assign ro_mon = ro_pad[sel];
  assign ro_sel = ro_pad[sel_q];

  ro_sync_edge u_sync (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_ni (wb_rst_ni),
    .d_async   (ro_sel),
    .rise      (rise)
  );

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    gate_d       = gate_q;
    gate_rem_d   = gate_rem_q;
    settle_cnt_d = settle_cnt_q;
    edge_cnt_d   = edge_cnt_q;
    ovf_d        = ovf_q;
    count_d      = count_q;
    overflow_d   = overflow_q;
    done_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d      = SETTLE;
          sel_d        = sel;
          gate_d       = gate_cycles;
          edge_cnt_d   = '0;
          ovf_d        = 1'b0;
          settle_cnt_d = SETTLE_W'(SETTLE_CYCLES);
        end
      end
      SETTLE: begin
        // Synchroniser still holds the previous channel; count nothing here.
        if (settle_cnt_q == SETTLE_W'(1)) begin
          if (gate_q == '0) begin
            state_d = DONE;
          end else begin
            state_d    = GATE;
            gate_rem_d = gate_q;
          end
        end else begin
          settle_cnt_d = settle_cnt_q - SETTLE_W'(1);
        end
      end
      GATE: begin
        if (rise) begin
          // Saturate rather than wrap so a too-fast ring is flagged.
          if (edge_cnt_q == '1) begin
            ovf_d = 1'b1;
          end else begin
            edge_cnt_d = edge_cnt_q + CNT_W'(1);
          end
        end
        gate_rem_d = gate_rem_q - GATE_W'(1);
        if (gate_rem_q == GATE_W'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        count_d    = edge_cnt_q;
        overflow_d = ovf_q;
        done_d     = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Abort discards the measurement and leaves the published result alone.
    if (abort && (state_q != IDLE)) begin
      state_d    = IDLE;
      done_d     = 1'b0;
      count_d    = count_q;
      overflow_d = overflow_q;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q      <= IDLE;
      sel_q        <= '0;
      gate_q       <= '0;
      gate_rem_q   <= '0;
      settle_cnt_q <= '0;
      edge_cnt_q   <= '0;
      ovf_q        <= 1'b0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      gate_q       <= gate_d;
      gate_rem_q   <= gate_rem_d;
      settle_cnt_q <= settle_cnt_d;
      edge_cnt_q   <= edge_cnt_d;
      ovf_q        <= ovf_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      done_q       <= done_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_ro_freq_meter.sv
// Directed testbench for ro_freq_meter. Two instances share all inputs:
// the default configuration and a CNT_W=4 copy for saturation.
module tb_ro_freq_meter;

  logic        clk;
  logic        rst_n;
  logic [9:0]  ro_in;
  logic [3:0]  sel_i;
  logic [15:0] gate_i;
  logic        start;
  logic        abort;

  logic        busy, done, overflow, ro_mon;
  logic [23:0] count;
  logic        busy4, done4, ovf4, mon4;
  logic [3:0]  count4;

  logic [2:0]  ph;

  int checks   = 0;
  int failures = 0;
  int k;
  int seen;

  ro_freq_meter #(.N_CH(10)) dut (
    .wb_clk_i    (clk),
    .wb_rst_ni   (rst_n),
    .ro_in       (ro_in),
    .sel         (sel_i),
    .gate_cycles (gate_i),
    .start       (start),
    .abort       (abort),
    .busy        (busy),
    .done        (done),
    .count       (count),
    .overflow    (overflow),
    .ro_mon      (ro_mon)
  );

  ro_freq_meter #(.N_CH(10), .CNT_W(4)) dut4 (
    .wb_clk_i    (clk),
    .wb_rst_ni   (rst_n),
    .ro_in       (ro_in),
    .sel         (sel_i),
    .gate_cycles (gate_i),
    .start       (start),
    .abort       (abort),
    .busy        (busy4),
    .done        (done4),
    .count       (count4),
    .overflow    (ovf4),
    .ro_mon      (mon4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Oscillators: ro_in[0] = f/2, ro_in[3] = f/4, ro_in[5] = f/8.
  initial begin
    ph    = '0;
    ro_in = '0;
    forever begin
      @(negedge clk);
      ph = ph + 3'd1;
      ro_in    = '0;
      ro_in[0] = ph[0];
      ro_in[3] = ph[1];
      ro_in[5] = ph[2];
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_rng(input string tag, input logic [63:0] obs, input int lo, input int hi);
    checks++;
    assert (((obs >= 64'(lo)) && (obs <= 64'(hi))) === 1'b1) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    end
  endtask

  // Present start for one edge; returns at that edge + 1 time unit.
  task automatic kick(input logic [3:0] s, input logic [15:0] g);
    @(negedge clk);
    sel_i  = s;
    gate_i = g;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
  endtask

  // Waits for done; n = edges after the start edge, or -1 on timeout.
  task automatic wait_done(input int maxc, output int n);
    n = -1;
    for (int i = 1; i <= maxc; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    abort  = 1'b0;
    sel_i  = 4'd0;
    gate_i = 16'd0;

    // Reset held with oscillators toggling.
    repeat (5) @(negedge clk);
    check_eq("rst_busy",     busy,     1'b0);
    check_eq("rst_done",     done,     1'b0);
    check_eq("rst_count",    count,    24'd0);
    check_eq("rst_overflow", overflow, 1'b0);
    check_eq("rst_count4",   count4,   4'd0);
    check_eq("rst_busy4",    busy4,    1'b0);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check_eq("idle_busy",     busy,     1'b0);
    check_eq("idle_done",     done,     1'b0);
    check_eq("idle_count",    count,    24'd0);
    check_eq("idle_overflow", overflow, 1'b0);
    check_eq("idle_done4",    done4,    1'b0);

    // Live pad mux.
    sel_i = 4'd3;
    #1;
    check_eq("mon_ch3", ro_mon, ph[1]);
    sel_i = 4'd5;
    #1;
    check_eq("mon_ch5",  ro_mon, ph[2]);
    check_eq("mon4_ch5", mon4,   ph[2]);

    // Known frequency f/4 over 100 cycles.
    kick(4'd3, 16'd100);
    check_eq("busy_after_start", busy, 1'b1);
    wait_done(400, k);
    check_eq("lat_g100", k + 1, 105);
    check_rng("count_g100", count, 24, 26);
    check_eq("ovf_g100", overflow, 1'b0);
    check_eq("busy_at_done", busy, 1'b0);

    // Zero-length gate.
    kick(4'd3, 16'd0);
    wait_done(50, k);
    check_eq("lat_g0", k + 1, 5);
    check_eq("count_g0", count, 24'd0);
    check_eq("ovf_g0", overflow, 1'b0);

    // Saturation: f/2 over 200 cycles.
    kick(4'd0, 16'd200);
    wait_done(400, k);
    check_eq("lat_g200", k + 1, 205);
    check_eq("sat_count4", count4, 4'd15);
    check_eq("sat_ovf4", ovf4, 1'b1);
    check_rng("nosat_count", count, 99, 101);
    check_eq("nosat_ovf", overflow, 1'b0);

    // Abort mid-GATE.
    kick(4'd3, 16'd50);
    repeat (20) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    check_eq("abort_busy", busy, 1'b0);
    seen = 0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) seen = 1;
    end
    check_eq("abort_no_done", seen, 0);
    check_eq("abort_keep_count4", count4, 4'd15);
    check_eq("abort_keep_ovf4", ovf4, 1'b1);

    // start together with abort in IDLE.
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    check_eq("start_abort_idle", busy, 1'b0);

    // Out-of-range select.
    kick(4'd12, 16'd20);
    wait_done(100, k);
    check_eq("lat_sel12", k + 1, 25);
    check_eq("count_sel12", count, 24'd0);
    check_eq("count4_sel12", count4, 4'd0);
    check_eq("ovf4_sel12", ovf4, 1'b0);
    check_eq("mon_sel12", ro_mon, 1'b0);

    // start re-pulsed mid-GATE with another channel is ignored.
    kick(4'd3, 16'd40);
    repeat (10) @(posedge clk);
    #1;
    sel_i = 4'd0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(100, k);
    check_eq("lat_restart", k + 12, 45);
    check_rng("count_restart", count, 9, 11);

    // Asynchronous reset mid-GATE.
    kick(4'd3, 16'd50);
    repeat (15) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("mrst_busy",     busy,     1'b0);
    check_eq("mrst_done",     done,     1'b0);
    check_eq("mrst_count",    count,    24'd0);
    check_eq("mrst_overflow", overflow, 1'b0);
    check_eq("mrst_count4",   count4,   4'd0);
    @(negedge clk);
    rst_n = 1'b1;
    kick(4'd3, 16'd20);
    wait_done(100, k);
    check_eq("lat_post_rst", k + 1, 25);
    check_rng("count_post_rst", count, 4, 6);
    check_eq("ovf_post_rst", overflow, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
